// File: rtl/axi_lite_manager.sv
// axi_lite_manager
// Single-outstanding AXI4-Lite manager. A command accepted on the cmd port is
// turned into one AW/W/B or AR/R transaction, and exactly one response is then
// presented on the rsp port. Every output is driven from a flop, so no VALID
// ever depends combinationally on the matching READY.
module axi_lite_manager #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    // command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wstrb,
    // response port
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,
    // write address channel
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [ADDR_W-1:0]     AWADDR,
    // write data channel
    output logic                  WVALID,
    input  logic                  WREADY,
    output logic [DATA_W-1:0]     WDATA,
    output logic [DATA_W/8-1:0]   WSTRB,
    // write response channel
    input  logic                  BVALID,
    output logic                  BREADY,
    input  logic [1:0]            BRESP,
    // read address channel
    output logic                  ARVALID,
    input  logic                  ARREADY,
    output logic [ADDR_W-1:0]     ARADDR,
    // read data channel
    input  logic                  RVALID,
    output logic                  RREADY,
    input  logic [DATA_W-1:0]     RDATA,
    input  logic [1:0]            RRESP
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_RSP     = 3'd5
    } state_e;

    state_e              state_q,     state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                awvalid_q,   awvalid_d;
    logic                wvalid_q,    wvalid_d;
    logic                aw_done_q,   aw_done_d;
    logic                w_done_q,    w_done_d;
    logic                bready_q,    bready_d;
    logic                arvalid_q,   arvalid_d;
    logic                rready_q,    rready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0]   awaddr_q,    awaddr_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic [STRB_W-1:0]   wstrb_q,     wstrb_d;
    logic [ADDR_W-1:0]   araddr_q,    araddr_d;
    logic                rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]          rsp_resp_q,  rsp_resp_d;

    // Handshake strobes; each one fires in the cycle before the edge that
    // completes the transfer.
    logic accept_s;
    logic aw_hs_s;
    logic w_hs_s;
    logic b_hs_s;
    logic ar_hs_s;
    logic r_hs_s;
    logic rsp_hs_s;

    assign accept_s = cmd_valid   & cmd_ready_q;
    assign aw_hs_s  = awvalid_q   & AWREADY;
    assign w_hs_s   = wvalid_q    & WREADY;
    assign b_hs_s   = bready_q    & BVALID;
    assign ar_hs_s  = arvalid_q   & ARREADY;
    assign r_hs_s   = rready_q    & RVALID;
    assign rsp_hs_s = rsp_valid_q & rsp_ready;

    // Next-state and next-output logic for the transaction sequencer.
    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        arvalid_d   = arvalid_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        araddr_d    = araddr_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    rsp_write_d = cmd_write;
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = ST_WR_REQ;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_REQ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WR_REQ: begin
                // AW and W retire independently, in either order.
                if (aw_hs_s) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end else begin
                    awvalid_d = awvalid_q;
                end
                if (w_hs_s) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end else begin
                    wvalid_d = wvalid_q;
                end
                if ((aw_done_q | aw_hs_s) & (w_done_q | w_hs_s)) begin
                    state_d = ST_WR_RESP;
                end else begin
                    state_d = ST_WR_REQ;
                end
            end

            ST_WR_RESP: begin
                if (b_hs_s) begin
                    rsp_resp_d  = BRESP;
                    rsp_rdata_d = '0;
                    state_d     = ST_RSP;
                end else begin
                    state_d = ST_WR_RESP;
                end
            end

            ST_RD_REQ: begin
                if (ar_hs_s) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_RD_RESP;
                end else begin
                    state_d = ST_RD_REQ;
                end
            end

            ST_RD_RESP: begin
                if (r_hs_s) begin
                    rsp_rdata_d = RDATA;
                    rsp_resp_d  = RRESP;
                    state_d     = ST_RSP;
                end else begin
                    state_d = ST_RD_RESP;
                end
            end

            ST_RSP: begin
                if (rsp_hs_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RSP;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                arvalid_d = 1'b0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
            end
        endcase

        // State-qualified strobes are registered from the next state so they
        // line up with the state they belong to.
        cmd_ready_d = (state_d == ST_IDLE);
        bready_d    = (state_d == ST_WR_RESP);
        rready_d    = (state_d == ST_RD_RESP);
        rsp_valid_d = (state_d == ST_RSP);
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            araddr_q    <= '0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            araddr_q    <= araddr_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign AWVALID   = awvalid_q;
    assign AWADDR    = awaddr_q;
    assign WVALID    = wvalid_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;
    assign BREADY    = bready_q;
    assign ARVALID   = arvalid_q;
    assign ARADDR    = araddr_q;
    assign RREADY    = rready_q;

endmodule

// File: doc/axi_lite_manager.md
# axi_lite_manager

Single-outstanding AXI4-Lite manager that turns a simple valid/ready command port into AW/W/B or AR/R transactions on `axi4_if` and returns one response per command. Sits directly upstream of the AXI subordinate: its AW/W/AR outputs drive the subordinate's RX channels, and it consumes the subordinate's B and R TX channels. It is the traffic source for CPU-side logic and for the bus testbench.

## Interface
- `ADDR_W`, default 32: width of the address field in AWADDR, ARADDR and cmd_addr.
- `DATA_W`, default 32: width of the data fields in WDATA, RDATA, cmd_wdata and rsp_rdata. Must be a multiple of 8.
- `ACLK`  in  1  sole clock; everything is sampled on the rising edge.
- `ARESET`  in  1  reset, synchronous and active-high.
- `cmd_valid` in 1; `cmd_ready` out 1; `cmd_write` in 1 (1 = write, 0 = read).
- `cmd_addr` in ADDR_W; `cmd_wdata` in DATA_W; `cmd_wstrb` in DATA_W/8.
- `rsp_valid` out 1; `rsp_ready` in 1; `rsp_write` out 1 (echo of cmd_write).
- `rsp_rdata` out DATA_W (0 for writes); `rsp_resp` out 2 (captured BRESP/RRESP).
- `AWVALID` out 1, `AWREADY` in 1, `AWADDR` out ADDR_W.
- `WVALID` out 1, `WREADY` in 1, `WDATA` out DATA_W, `WSTRB` out DATA_W/8.
- `BVALID` in 1, `BREADY` out 1, `BRESP` in 2.
- `ARVALID` out 1, `ARREADY` in 1, `ARADDR` out ADDR_W.
- `RVALID` in 1, `RREADY` out 1, `RDATA` in DATA_W, `RRESP` in 2.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: `cmd_ready` = 1. On `cmd_valid` the command is accepted; `cmd_addr`, `cmd_wdata`, `cmd_wstrb` and `cmd_write` are registered. The FSM moves to WR_REQ if `cmd_write` = 1, otherwise to RD_REQ.
- WR_REQ: AWVALID and WVALID both rise together. Each channel tracks its own done flag and drops its VALID on the edge after its own handshake, so AW and W may complete in either order or together. When both done flags are set, the FSM moves to WR_RESP.
- WR_RESP: BREADY = 1. On BVALID, BRESP is captured into `rsp_resp`, `rsp_rdata` is set to 0, and the FSM moves to RSP.
- RD_REQ: ARVALID = 1 until the AR handshake, then the FSM moves to RD_RESP.
- RD_RESP: RREADY = 1. On RVALID, RDATA and RRESP are captured and the FSM moves to RSP.
- RSP: `rsp_valid` = 1 and the response fields are held stable. On `rsp_ready` the FSM returns to IDLE.
- All VALID outputs are registered and never depend combinationally on the matching READY. ADDR, DATA and STRB stay stable while VALID is high and are held after the handshake.
- BVALID is ignored outside WR_RESP; RVALID is ignored outside RD_RESP. BREADY and RREADY are 0 in every other state.
- Only one transaction is in flight at a time. `cmd_ready` is 0 in every state except IDLE.
- RRESP/BRESP values are passed through unchanged. A response of 2'b10 or 2'b11 is still a completed transaction.

## Timing
- Reset (ARESET high at an edge): state goes to IDLE.
  - Every VALID and READY output is 0, and `rsp_valid` is 0.
  - AWADDR, WDATA, WSTRB, ARADDR, `rsp_rdata`, `rsp_resp` and `rsp_write` are all 0.
  - `cmd_ready` = 0 while ARESET is high and 1 on the first cycle after release.
- Reset mid-transaction abandons the transaction. VALIDs are low on the next edge and no response is produced.
- Cycle numbering: command accepted at edge 0; AWVALID/WVALID (or ARVALID) are high in cycle 1.
- Best-case write, with AWREADY = WREADY = 1 and BVALID arriving on the cycle BREADY first rises:
  - handshakes at edge 1, BREADY high in cycle 2, B captured at edge 2;
  - `rsp_valid` high in cycle 3, then `cmd_ready` high again in cycle 4 if `rsp_ready` = 1.
- Best-case read has the same 3-cycle command-to-`rsp_valid` latency.
- Back-to-back commands: throughput is at most one command per 4 cycles.
- `rsp_valid` held with `rsp_ready` = 0: the FSM stays in RSP indefinitely and no new command is accepted.

## Test plan
- Write, all READYs tied 1: cmd addr 0x10, data 0xDEADBEEF, strb 0xF. Required: AWADDR = 0x10 and WDATA = 0xDEADBEEF in cycle 1; `rsp_valid` in cycle 3 with `rsp_resp` = 0, `rsp_write` = 1.
- Skewed write: AWREADY delayed 3 cycles, WREADY immediate. Required: WVALID drops after edge 1, AWVALID stays high until its handshake, BREADY only after both complete, exactly one response.
- Read at 0x20, subordinate returns 0x12345678 with RRESP 2'b00 after 2 wait cycles. Required: `rsp_rdata` = 0x12345678, `rsp_write` = 0, ARVALID low after its handshake.
- Error pass-through: BRESP = 2'b10 on a write. Required: `rsp_resp` = 2'b10. A spurious BVALID pulse during IDLE is ignored and yields no response.
- Backpressure: hold `rsp_ready` = 0 for 5 cycles with a second `cmd_valid` pending. Required: `cmd_ready` stays 0 and `rsp_rdata` is stable; the second command is accepted one cycle after the `rsp_ready` handshake.
- Reset asserted in WR_RESP. Required: all VALID/READY outputs 0 and `rsp_valid` 0 after the edge; `cmd_ready` = 1 on the first cycle after release; the next read completes normally.
